// File: rtl/spi_master_param_if.sv
// Host and pin signals of the parametrised SPI master, bundled for port use.
// The master modport is the SPI master's own view; the slave modport is the
// view of whatever drives it (host logic and the SPI slave device).
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
);
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              start;
  logic [1:0]        mode;
  logic              lsb_first;
  logic [DIV_W-1:0]  clkdiv;
  logic [SS_W-1:0]   ss_sel;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] ss_n;

  modport master (
    input  start, mode, lsb_first, clkdiv, ss_sel, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, ss_n
  );

  modport slave (
    output start, mode, lsb_first, clkdiv, ss_sel, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master running entirely on the system clock. sclk is a
// registered output produced by the FSM, never used as a clock. Frame width,
// slave count and divider width are parameters; mode, bit order, divider and
// slave index are latched per transfer.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
) (
  input logic                clk,
  input logic                rst,
  spi_master_param_if.master bus
);
  localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int BC_W  = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [SS_W:0] SS_LIMIT = (SS_W + 1)'(NUM_SS);

  typedef enum logic [2:0] {IDLE, SETUP, LEAD, TRAIL, HOLD} state_t;

  state_t            state;
  logic [DIV_W-1:0]  hcnt;
  logic [DIV_W-1:0]  div_q;
  logic [BC_W-1:0]   bit_cnt;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_sr;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] rx_r;
  logic              sclk_r;
  logic              mosi_r;
  logic [NUM_SS-1:0] ss_n_r;

  // Physical bit position of the k-th bit on the wire. Transmit and receive
  // share it, so received bits land where they were sent from.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [BC_W-1:0] k,
                                               input logic lsb);
    logic [BC_W-1:0] p;
    p = lsb ? k : (BC_W'(DATA_W - 1) - k);
    return p[IDX_W-1:0];
  endfunction

  logic            ss_ok;
  logic            accept;
  logic            tick;
  logic            last_bit;
  logic            lead_ev;
  logic            trail_ev;
  logic [BC_W-1:0] bit_nxt;

  assign ss_ok    = {1'b0, bus.ss_sel} < SS_LIMIT;
  assign accept   = (state == IDLE) && bus.start && ss_ok;
  assign tick     = (state != IDLE) && (hcnt == '0);
  assign last_bit = (bit_cnt == BC_W'(DATA_W));
  // Clock edge that moves sclk to its leading (non-idle) level.
  assign lead_ev  = tick && ((state == SETUP) || ((state == TRAIL) && !last_bit));
  // Clock edge that returns sclk to its idle level.
  assign trail_ev = tick && (state == LEAD);
  assign bit_nxt  = bit_cnt + 1'b1;

  // Control FSM: acceptance, half-period timing, sequencing and pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hcnt    <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rx_r    <= '0;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
      ss_n_r  <= '1;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        // Idle clock level tracks the live CPOL so the bus parks correctly
        // before the first select.
        sclk_r <= bus.mode[1];
        if (accept) begin
          state   <= SETUP;
          hcnt    <= bus.clkdiv;
          div_q   <= bus.clkdiv;
          bit_cnt <= '0;
          cpol_q  <= bus.mode[1];
          cpha_q  <= bus.mode[0];
          lsb_q   <= bus.lsb_first;
          busy_r  <= 1'b1;
          ss_n_r  <= ~(NUM_SS'(1) << bus.ss_sel);
          mosi_r  <= bus.mode[0] ? 1'b0 : bus.tx_data[bit_pos('0, bus.lsb_first)];
        end
      end else if (!tick) begin
        hcnt <= hcnt - 1'b1;
      end else begin
        hcnt <= div_q;
        unique case (state)
          SETUP, TRAIL: begin
            if (lead_ev) begin
              state  <= LEAD;
              sclk_r <= ~cpol_q;
              if (cpha_q) mosi_r <= tx_q[bit_pos(bit_cnt, lsb_q)];
            end else begin
              state <= HOLD;
            end
          end
          LEAD: begin
            state   <= TRAIL;
            sclk_r  <= cpol_q;
            bit_cnt <= bit_nxt;
            // CPHA=0 shifts on trailing edges, but not after the final bit.
            if (!cpha_q && (bit_cnt < BC_W'(DATA_W - 1)))
              mosi_r <= tx_q[bit_pos(bit_nxt, lsb_q)];
          end
          HOLD: begin
            state   <= IDLE;
            hcnt    <= '0;
            bit_cnt <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            rx_r    <= rx_sr;
            ss_n_r  <= '1;
            mosi_r  <= 1'b0;
            sclk_r  <= bus.mode[1];
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Frame data: latch transmit frame at acceptance, capture miso in place on
  // the edge selected by CPHA (leading for CPHA=0, trailing for CPHA=1).
  always_ff @(posedge clk) begin
    if (accept) tx_q <= bus.tx_data;
    if ((lead_ev && !cpha_q) || (trail_ev && cpha_q))
      rx_sr[bit_pos(bit_cnt, lsb_q)] <= bus.miso;
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rx_data = rx_r;
  assign bus.sclk    = sclk_r;
  assign bus.mosi    = mosi_r;
  assign bus.ss_n    = ss_n_r;
endmodule

// File: tb/tb_spi_master_param.sv
// Testbench for spi_master_param: an 8-bit/4-slave instance with a behavioural
// SPI slave (or loopback), and a 16-bit/1-slave instance in loopback.
module tb_spi_master_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(8),  .NUM_SS(4), .DIV_W(8)) b8();
  spi_master_param_if #(.DATA_W(16), .NUM_SS(1), .DIV_W(8)) b16();

  spi_master_param #(.DATA_W(8),  .NUM_SS(4), .DIV_W(8)) u_dut8  (.clk(clk), .rst(rst), .bus(b8));
  spi_master_param #(.DATA_W(16), .NUM_SS(1), .DIV_W(8)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));

  int errors = 0;
  int checks = 0;

  logic [15:0] q8[$];   // {expected rx_data, expected slave-received frame}
  logic [15:0] q16[$];  // expected rx_data

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural SPI slave on the 8-bit bus
  logic       lb = 1'b1;
  logic [1:0] s_mode = 2'b00;
  logic       s_lsb = 1'b0;
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic [1:0] s_sel = 2'd0;
  logic       s_miso = 1'b0;
  logic       s_act = 1'b0;
  logic       s_sclk_prev = 1'b0;
  int         s_cnt = 0;

  function automatic int s_pos(input int k, input logic lsb);
    return lsb ? k : 7 - k;
  endfunction

  assign b8.miso  = lb ? b8.mosi : s_miso;
  assign b16.miso = b16.mosi;

  always @(negedge clk) begin
    if (!b8.ss_n[s_sel] && !s_act) begin
      s_cnt = 0;
      s_rx  = 8'h00;
      if (!s_mode[0]) s_miso = s_tx[s_pos(0, s_lsb)];
    end else if (!b8.ss_n[s_sel] && (b8.sclk != s_sclk_prev)) begin
      if (b8.sclk != s_mode[1]) begin
        if (!s_mode[0]) s_rx[s_pos(s_cnt, s_lsb)] = b8.mosi;
        else            s_miso = s_tx[s_pos(s_cnt, s_lsb)];
      end else begin
        if (s_mode[0]) begin
          s_rx[s_pos(s_cnt, s_lsb)] = b8.mosi;
          s_cnt++;
        end else begin
          s_cnt++;
          if (s_cnt < 8) s_miso = s_tx[s_pos(s_cnt, s_lsb)];
        end
      end
    end
    s_act       = !b8.ss_n[s_sel];
    s_sclk_prev = b8.sclk;
  end

  // Scoreboard monitors: pop an expectation whenever a DUT presents done
  logic [15:0] e8;
  logic [15:0] e16;
  always @(negedge clk) begin
    if (b8.done) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL done8_unexpected: got done=1 expected no done");
      end else begin
        e8 = q8.pop_front();
        chk("rx8", int'(b8.rx_data), int'(e8[15:8]));
        chk("slave_rx8", int'(s_rx), int'(e8[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (b16.done) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL done16_unexpected: got done=1 expected no done");
      end else begin
        e16 = q16.pop_front();
        chk("rx16", int'(b16.rx_data), int'(e16));
      end
    end
  end

  // One frame on the 8-bit DUT with timing checks; pert pokes inputs mid-frame
  task automatic frame8(input logic [1:0] m, input logic lsb, input logic [7:0] div,
                        input logic [1:0] sel, input logic [7:0] tx, input logic loop_en,
                        input logic [7:0] stx, input logic pert);
    int cyc, leads, first_lead, last_lead, ss_bad, h;
    logic prev_sclk;
    logic [3:0] exp_ss;
    h = int'(div) + 1;
    @(negedge clk);
    b8.mode = m; b8.lsb_first = lsb; b8.clkdiv = div; b8.ss_sel = sel; b8.tx_data = tx;
    lb = loop_en; s_mode = m; s_lsb = lsb; s_tx = stx; s_sel = sel;
    b8.start = 1'b1;
    q8.push_back({loop_en ? tx : stx, tx});
    exp_ss = ~(4'b0001 << sel);
    prev_sclk = m[1]; leads = 0; first_lead = 0; last_lead = 0; ss_bad = 0;
    @(negedge clk);
    b8.start = 1'b0;
    cyc = 1;
    chk("busy_c1", int'(b8.busy), 1);
    chk("ss_n_c1", int'(b8.ss_n), int'(exp_ss));
    chk("sclk_c1_cpol", int'(b8.sclk), int'(m[1]));
    while (!b8.done && cyc < 3000) begin
      if (b8.sclk != prev_sclk && b8.sclk != m[1]) begin
        leads++;
        if (first_lead == 0) first_lead = cyc;
        last_lead = cyc;
      end
      if (b8.ss_n != exp_ss) ss_bad++;
      prev_sclk = b8.sclk;
      if (pert && cyc == 10) begin
        b8.start = 1'b1; b8.tx_data = ~tx; b8.mode = ~m; b8.lsb_first = ~lsb;
        b8.ss_sel = sel + 2'd1; b8.clkdiv = 8'd0;
      end
      if (pert && cyc == 11) begin
        b8.start = 1'b0; b8.tx_data = tx; b8.mode = m; b8.lsb_first = lsb;
        b8.ss_sel = sel; b8.clkdiv = div;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_cycle", cyc, 2 * h * 9 + 1);
    chk("lead_edges", leads, 8);
    chk("first_lead_cycle", first_lead, h + 1);
    chk("last_lead_cycle", last_lead, h + 1 + 2 * h * 7);
    chk("ss_n_in_frame", ss_bad, 0);
    chk("ss_n_after", int'(b8.ss_n), 'hF);
    chk("busy_after", int'(b8.busy), 0);
    chk("sclk_idle", int'(b8.sclk), int'(m[1]));
  endtask

  // One loopback frame on the 16-bit DUT with clkdiv=0
  task automatic frame16(input logic [1:0] m, input logic lsb, input logic [15:0] tx);
    int cyc, leads, first_lead, last_lead, ss_bad;
    logic prev_sclk;
    @(negedge clk);
    b16.mode = m; b16.lsb_first = lsb; b16.clkdiv = 8'd0; b16.ss_sel = 1'b0;
    b16.tx_data = tx; b16.start = 1'b1;
    q16.push_back(tx);
    prev_sclk = m[1]; leads = 0; first_lead = 0; last_lead = 0; ss_bad = 0;
    @(negedge clk);
    b16.start = 1'b0;
    cyc = 1;
    while (!b16.done && cyc < 3000) begin
      if (b16.sclk != prev_sclk && b16.sclk != m[1]) begin
        leads++;
        if (first_lead == 0) first_lead = cyc;
        last_lead = cyc;
      end
      if (b16.ss_n != 1'b0) ss_bad++;
      prev_sclk = b16.sclk;
      @(negedge clk);
      cyc++;
    end
    chk("done16_cycle", cyc, 35);
    chk("lead16_edges", leads, 16);
    chk("first16_lead", first_lead, 2);
    chk("last16_lead", last_lead, 32);
    chk("ss16_in_frame", ss_bad, 0);
    chk("ss16_after", int'(b16.ss_n), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    b8.start = 1'b0; b8.mode = 2'b00; b8.lsb_first = 1'b0; b8.clkdiv = 8'd0;
    b8.ss_sel = 2'd0; b8.tx_data = 8'h00;
    b16.start = 1'b0; b16.mode = 2'b00; b16.lsb_first = 1'b0; b16.clkdiv = 8'd0;
    b16.ss_sel = 1'b0; b16.tx_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", int'(b8.ss_n), 'hF);
    chk("rst_sclk", int'(b8.sclk), 0);
    chk("rst_mosi", int'(b8.mosi), 0);
    chk("rst_busy", int'(b8.busy), 0);
    chk("rst_done", int'(b8.done), 0);
    chk("rst_rx", int'(b8.rx_data), 0);
    chk("rst_ss16", int'(b16.ss_n), 1);
    rst = 1'b0;

    // Mode 0 loopback, clkdiv=1, slave 2
    frame8(2'b00, 1'b0, 8'd1, 2'd2, 8'hA5, 1'b1, 8'h00, 1'b0);

    // All modes, MSB and LSB first, slave model returns 0x3C
    for (int i = 0; i < 8; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      frame8(iv[2:1], iv[0], 8'(i % 3), iv[1:0], 8'hC3, 1'b0, 8'h3C, 1'b0);
    end

    // Back-to-back: start held high across done
    @(negedge clk);
    b8.mode = 2'b01; b8.lsb_first = 1'b0; b8.clkdiv = 8'd0; b8.ss_sel = 2'd3;
    b8.tx_data = 8'h81; lb = 1'b1; s_mode = 2'b01; s_lsb = 1'b0; s_sel = 2'd3;
    b8.start = 1'b1;
    q8.push_back({8'h81, 8'h81});
    cyc = 0;
    while (!b8.done && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("b2b_done1_cycle", cyc, 19);
    chk("b2b_ss_gap", int'(b8.ss_n), 'hF);
    b8.tx_data = 8'h7E;
    q8.push_back({8'h7E, 8'h7E});
    @(negedge clk);
    b8.start = 1'b0;
    chk("b2b_ss_low", int'(b8.ss_n), 'h7);
    chk("b2b_busy", int'(b8.busy), 1);
    cyc = 1;
    while (!b8.done && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("b2b_done2_cycle", cyc, 19);
    repeat (3) @(negedge clk);
    chk("b2b_idle_busy", int'(b8.busy), 0);

    // Start pulsed with altered inputs mid-transfer
    frame8(2'b10, 1'b1, 8'd0, 2'd1, 8'h96, 1'b0, 8'h5B, 1'b1);

    // Reset after three bits of a frame
    @(negedge clk);
    b8.mode = 2'b00; b8.lsb_first = 1'b0; b8.clkdiv = 8'd1; b8.ss_sel = 2'd1;
    b8.tx_data = 8'h5A; lb = 1'b1; s_sel = 2'd1; s_mode = 2'b00; s_lsb = 1'b0;
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", int'(b8.busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ss_n", int'(b8.ss_n), 'hF);
    chk("mid_rst_sclk", int'(b8.sclk), 0);
    chk("mid_rst_busy", int'(b8.busy), 0);
    chk("mid_rst_rx", int'(b8.rx_data), 0);
    chk("mid_rst_mosi", int'(b8.mosi), 0);
    @(negedge clk);
    rst = 1'b0;
    frame8(2'b11, 1'b0, 8'd2, 2'd0, 8'h3D, 1'b1, 8'h00, 1'b0);

    // 16-bit, single slave, clkdiv=0
    frame16(2'b00, 1'b0, 16'hBEEF);
    frame16(2'b11, 1'b1, 16'h1234);

    // Out-of-range slave index on the single-slave instance
    @(negedge clk);
    b16.ss_sel = 1'b1; b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    chk("bad_sel_busy", int'(b16.busy), 0);
    chk("bad_sel_ss_n", int'(b16.ss_n), 1);
    repeat (6) @(negedge clk);
    chk("bad_sel_busy_late", int'(b16.busy), 0);
    chk("bad_sel_ss_n_late", int'(b16.ss_n), 1);

    repeat (4) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
